// File: rtl/moore_seq_detector.sv
// moore_seq_detector
// Parametrised Moore-type serial pattern detector for an arbitrary N-bit
// PATTERN. Detection can be overlapping (ovl=1) or non-overlapping (ovl=0),
// and is selected at run time.
// The state is the number of pattern bits matched so far, 0..N. The
// next-state table is the KMP automaton for PATTERN, built at elaboration
// by a constant function.
// Optional feature: define SEQDET_COUNT_EN to build the saturating match
// counter and its synchronous clear. Without it, count is tied to 0 and
// clr is ignored.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   0     | no pattern bits matched
//   1..N-1| that many leading pattern bits are matched
//   N     | full pattern matched; z is high
module moore_seq_detector #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1010,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             ovl,
  input  logic             clr,
  output logic             z,
  output logic [CNT_W-1:0] count
);

  localparam int              SW     = $clog2(N + 1);
  localparam int              TAB_W  = 2 * (N + 1) * SW;
  localparam logic [SW-1:0]   S_FULL = SW'(N);

  // Builds the KMP transition table. Entry (2*s + b) holds the length of the
  // longest pattern prefix that is a suffix of "first s pattern bits, then b".
  // The result is capped at N, so row N uses the longest proper border of
  // PATTERN. That row serves the overlapping restart.
  function automatic logic [TAB_W-1:0] build_tab();
    logic [TAB_W-1:0] tab;
    logic [16:0]      pf;
    logic [16:0]      str;
    int               len;
    int               best;
    bit               ok;
    tab = '0;
    pf  = '0;
    for (int j = 0; j < N; j++) pf[j] = PATTERN[N-1-j];
    for (int s = 0; s <= N; s++) begin
      for (int b = 0; b < 2; b++) begin
        str    = pf;
        str[s] = b[0];
        len    = s + 1;
        best   = 0;
        for (int k = 1; k <= N; k++) begin
          if (k <= len) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
              if (pf[j] != str[len-k+j]) ok = 1'b0;
            end
            if (ok) best = k;
          end
        end
        tab[(2*s+b)*SW +: SW] = SW'(best);
      end
    end
    return tab;
  endfunction

  localparam logic [TAB_W-1:0] NEXT_TAB = build_tab();

  logic [SW-1:0] state;
  logic [SW-1:0] state_next;
  int            tab_idx;

  // Next-state selection. ovl only matters when leaving the full-match state.
  always_comb begin
    state_next = state;
    tab_idx    = 2 * int'(state) + int'(x);
    if (en) begin
      if (state == S_FULL && !ovl)
        state_next = (x == PATTERN[N-1]) ? SW'(1) : '0;
      else
        state_next = NEXT_TAB[tab_idx*SW +: SW];
    end
  end

  // State register, plus z registered alongside it so z == (state == N).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= '0;
      z     <= 1'b0;
    end else begin
      state <= state_next;
      z     <= (state_next == S_FULL);
    end
  end

`ifdef SEQDET_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic hit;
  assign hit = en && (state_next == S_FULL);

  // Saturating match counter. A clear takes priority over a match in the
  // same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (hit && count != CNT_MAX)
      count <= count + CNT_W'(1);
  end
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign count      = '0;
`endif

endmodule

// File: doc/moore_seq_detector.md
# moore_seq_detector

Parametrised Moore-type serial pattern detector, the generalised successor to the fixed 4-bit overlapping detectors in the Moore FSM collection. It detects an arbitrary N-bit pattern on a 1-bit serial input and supports both overlapping and non-overlapping detection, selectable at run time. It adds a clock-enable and an optional saturating match counter. It sits directly on a serial bit stream and drives a registered single-cycle match flag.

## Interface
- N, 4, pattern length in bits; legal range 2..16
- PATTERN, 4'b1010, N-bit pattern; PATTERN[N-1] is the first bit received, PATTERN[0] the last
- CNT_W, 8, match counter width; legal range 1..32

- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-high
- en  input  1  bit-valid / clock enable; x is consumed only when en=1
- x  input  1  serial data bit
- ovl  input  1  mode: 1 = overlapping, 0 = non-overlapping detection
- clr  input  1  synchronous clear of count; effective only with SEQDET_COUNT_EN
- z  output  1  match flag; Moore output, high while FSM is in state N
- count  output  CNT_W  number of matches since reset/clear; saturating

## Operation
- State s in 0..N = number of pattern bits currently matched; state register width is clog2(N+1).
- z = (s == N). z is a pure function of the state register, with no combinational path from x, ovl or en.
- Transition for s < N when en=1: s' = length of the longest prefix of PATTERN that is a suffix of (matched prefix of length s, followed by x). This is the KMP next-state function.
- The transition table is computed at elaboration from PATTERN by a constant function. No pattern-specific hand-coding is allowed.
- Transition from s = N when en=1:
  - ovl=1: s' = KMP next state from the full pattern followed by x, using the longest proper border of PATTERN.
  - ovl=0: s' = 1 if x == PATTERN[N-1], else 0. No matched bits are reused.
- en=0: s holds and count holds. While in state N, z stays high for as long as en=0.
- count (SEQDET_COUNT_EN only): increments by 1 on each clock edge that moves s into N, and stops at 2^CNT_W-1.
- clr=1 sets count to 0 at the next edge. If clr and an increment occur in the same cycle, clr wins and count is 0.
- ovl is sampled only on edges that leave state N. Changing ovl at any other time has no effect.

## Timing
- Reset (rst=1, asynchronous): s=0, z=0, count=0 immediately, without waiting for a clock edge.
- Release of rst is synchronous to the next rising edge.
- Latency: the last pattern bit is sampled on edge k, and z is high in the cycle following edge k, i.e. from edge k until edge k+1.
- z pulse width is 1 cycle per match when en is held at 1.
- Back-to-back overlapping matches: z stays high on consecutive cycles when the pattern border allows it (e.g. 111 on an all-ones stream).
- count updates on the same edge at which z rises.
- rst asserted mid-pattern discards any partial match. Detection restarts from s=0.

## Configuration
- Macro SEQDET_COUNT_EN defined:
  - The CNT_W-bit saturating counter and clr logic are built.
  - count behaves as described above.
- Macro SEQDET_COUNT_EN undefined:
  - No counter logic is built and clr is ignored.
  - count is tied to constant 0.
  - Ports are identical in both builds.

## Test plan
- Default params, ovl=1, en=1, stream 1,1,0,1,0,1,0,1,1,1,0,1,0,1,0 after reset release:
  - z is high in the cycle after bits 5, 7, 13 and 15.
  - count=4 with SEQDET_COUNT_EN.
- Same stream with ovl=0:
  - z is high only after bits 5 and 13.
  - count=2.
- N=3, PATTERN=3'b111, six consecutive 1s:
  - ovl=1: z is high after bits 3, 4, 5 and 6.
  - ovl=0: z is high after bits 3 and 6 only.
- Default params, stream 1,0,1,0 with en=0 for 3 cycles between bits 2 and 3:
  - The partial match is held.
  - z rises exactly once, in the cycle after bit 4.
- rst asserted asynchronously mid-cycle after bits 1,0,1:
  - z and count go to 0 immediately.
  - The following single bit 0 does not produce z.
- CNT_W=2, ovl=1, 5 matches: count saturates at 3.
  - clr pulsed in the same cycle as a 6th match gives count=0.
